// File: rtl/pr3_pkg.sv
// Shared constants for the antenna tone generator: FSM states,
// datapath latency and the dither LFSR definition.
package pr3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // accumulator -> LUT read -> sign/shift/output register
    localparam int TONE_LAT = 3;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci taps on bits 15,13,12,10
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    // one distinct nonzero seed per antenna, index 0 = antenna #1
    localparam logic [2:0][15:0] LFSR_SEED = {16'h7A35, 16'h1D2F, 16'hACE1};

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM with a registered read port.
// Entry i = round((2^(WIDTH-1)-1) * sin(2*pi*(i+0.5)/2^(LUT_AW+2))).
// The half-step offset keeps the table symmetric so mirroring is a bit flip.
module sine_quarter_lut #(
    parameter int WIDTH  = 14,
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-1:0] addr,
    output logic [WIDTH-2:0]  mag
);

    localparam int DEPTH = 2 ** LUT_AW;

    typedef logic [DEPTH-1:0][WIDTH-2:0] rom_t;

    function automatic rom_t gen_rom();
        rom_t r;
        real  pk;
        real  x;
        pk = (2.0 ** (WIDTH - 1)) - 1.0;
        for (int i = 0; i < DEPTH; i++) begin
            x    = pk * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / real'(4 * DEPTH));
            r[i] = (WIDTH-1)'($rtoi(x + 0.5));
        end
        return r;
    endfunction

    localparam rom_t ROM = gen_rom();

    // Registered ROM read; the table is entirely elaboration-time constant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mag <= '0;
        else        mag <= ROM[addr];
    end

endmodule

// File: rtl/antenna_tone_gen.sv
// Three-antenna synthetic tone source framed into RUNS frames of 2^FFT samples.
// Optional dither: define ANT_NOISE_EN to add a per-antenna LFSR dither of
// -2..+1 LSB after the attenuation shift, saturated to the output range.
module antenna_tone_gen
    import pr3_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int FFT     = 11,
    parameter int RUNS    = 1,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phi2,
    input  logic [PHASE_W-1:0] phi3,
    input  logic [3:0]         amp_shift,
    output logic [WIDTH-1:0]   data1,
    output logic [WIDTH-1:0]   data2,
    output logic [WIDTH-1:0]   data3,
    output logic               valid,
    output logic               sop,
    output logic               eop,
    output logic               busy,
    output logic               done
);

    localparam int NANT = 3;
    localparam int QW   = LUT_AW + 2;
    localparam int FRW  = (RUNS > 1) ? $clog2(RUNS) : 1;

    state_t                        state;
    logic [PHASE_W-1:0]            fw_q, phi2_q, phi3_q, acc;
    logic [3:0]                    amp_q;
    logic [FFT-1:0]                smp_cnt;
    logic [FRW-1:0]                frm_cnt;
    logic                          stop_seen;
    logic                          issue, last_smp, last_frm, end_run;
    logic [TONE_LAT:1]             vld_pipe, sop_pipe, eop_pipe;
    logic [NANT-1:0][PHASE_W-1:0]  ph_off;
    logic [NANT-1:0][WIDTH-1:0]    dout;

    assign issue    = (state == RUN);
    assign last_smp = &smp_cnt;
    assign last_frm = (frm_cnt == FRW'(RUNS - 1));
    // a stop arriving with the eop sample still makes that eop the last one
    assign end_run  = last_smp && (last_frm || stop_seen || stop);
    assign ph_off   = {phi3_q, phi2_q, {PHASE_W{1'b0}}};

    // Command FSM: latch settings on start, count samples/frames, drain, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fw_q      <= '0;
            phi2_q    <= '0;
            phi3_q    <= '0;
            amp_q     <= '0;
            acc       <= '0;
            smp_cnt   <= '0;
            frm_cnt   <= '0;
            stop_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    fw_q      <= freq_word;
                    phi2_q    <= phi2;
                    phi3_q    <= phi3;
                    amp_q     <= amp_shift;
                    acc       <= '0;
                    smp_cnt   <= '0;
                    frm_cnt   <= '0;
                    stop_seen <= 1'b0;
                    busy      <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    acc     <= acc + fw_q;
                    smp_cnt <= smp_cnt + 1'b1;
                    if (stop)     stop_seen <= 1'b1;
                    if (last_smp) frm_cnt   <= frm_cnt + 1'b1;
                    if (end_run)  state     <= DRAIN;
                end
                DRAIN: if (vld_pipe == {1'b1, {(TONE_LAT-1){1'b0}}}) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid/sop/eop tags ride alongside their sample through the stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
            eop_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[TONE_LAT-1:1], issue};
            sop_pipe <= {sop_pipe[TONE_LAT-1:1], issue && (smp_cnt == '0)};
            eop_pipe <= {eop_pipe[TONE_LAT-1:1], issue && last_smp};
        end
    end

    assign valid = vld_pipe[TONE_LAT];
    assign sop   = sop_pipe[TONE_LAT];
    assign eop   = eop_pipe[TONE_LAT];

    for (genvar k = 0; k < NANT; k++) begin : g_ant
        logic [QW-1:0]            ph1;
        logic [LUT_AW-1:0]        idx;
        logic [WIDTH-2:0]         mag2;
        logic                     neg2;
        logic signed [WIDTH-1:0]  sgn, shf, res, out_q;

        // Stage 1: antenna phase, keeping only the LUT address bits.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)     ph1 <= '0;
            else if (issue) ph1 <= QW'((acc + ph_off[k]) >> (PHASE_W - QW));
        end

        // Quadrants 2 and 4 walk the quarter table backwards.
        assign idx = ph1[LUT_AW-1:0] ^ {LUT_AW{ph1[QW-2]}};

        sine_quarter_lut #(.WIDTH(WIDTH), .LUT_AW(LUT_AW)) u_lut (
            .clk   (clk),
            .reset (reset),
            .addr  (idx),
            .mag   (mag2)
        );

        // Stage 2: carry the half-cycle sign next to the registered LUT word.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) neg2 <= 1'b0;
            else        neg2 <= ph1[QW-1];
        end

        assign sgn = neg2 ? -$signed({1'b0, mag2}) : $signed({1'b0, mag2});
        assign shf = sgn >>> amp_q;

`ifdef ANT_NOISE_EN
        logic [15:0]           lfsr;
        logic [1:0]            dth1, dth2;
        logic signed [WIDTH:0] wide;

        // Dither source advances once per issued sample; its bits follow the sample.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lfsr <= LFSR_SEED[k];
                dth1 <= '0;
                dth2 <= '0;
            end else begin
                if (issue) begin
                    lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
                    dth1 <= lfsr[1:0];
                end
                dth2 <= dth1;
            end
        end

        assign wide = $signed({shf[WIDTH-1], shf}) + $signed({{(WIDTH-1){dth2[1]}}, dth2});
        assign res  = (wide[WIDTH] != wide[WIDTH-1])
                    ? {wide[WIDTH], {(WIDTH-1){~wide[WIDTH]}}}
                    : wide[WIDTH-1:0];
`else
        assign res = shf;
`endif

        // Stage 3: output register, held while no sample is presented.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                      out_q <= '0;
            else if (vld_pipe[TONE_LAT-1])   out_q <= res;
        end

        assign dout[k] = out_q;
    end

    assign data1 = dout[0];
    assign data2 = dout[1];
    assign data3 = dout[2];

endmodule

// File: doc/antenna_tone_gen.md
Name: antenna_tone_gen

Overview:
- Synthetic three-antenna sample source for bring-up and closed-loop test of the phase-extraction chain.
- Produces three phase-offset sine tones on Q<WIDTH>.0 buses, one sample per clock, framed into RUNS frames of 2^FFT samples.
- Drives the same antenna data buses that phase_extract consumes, so phase recovery can be checked against known offsets.

Parameters:
- WIDTH, 14: output bits per antenna (Q<WIDTH>.0).
- FFT, 11: log2 of frame length in samples.
- RUNS, 1: frames per start command.
- PHASE_W, 16: phase accumulator width (UQ0.PHASE_W turns).
- LUT_AW, 8: quarter-wave LUT address bits.

Ports:
- clk  in  1  sample clock (20.0 MHz in system).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start request; honoured only in IDLE.
- stop  in  1  ends generation at the next frame end.
- freq_word  in  PHASE_W  phase increment per sample (UQ0.PHASE_W).
- phi2  in  PHASE_W  antenna #2 phase offset vs #1.
- phi3  in  PHASE_W  antenna #3 phase offset vs #1.
- amp_shift  in  4  arithmetic right-shift attenuation.
- data1  out  WIDTH  antenna #1 sample (Q<WIDTH>.0).
- data2  out  WIDTH  antenna #2 sample (Q<WIDTH>.0).
- data3  out  WIDTH  antenna #3 sample (Q<WIDTH>.0).
- valid  out  1  data1..3 valid this cycle.
- sop  out  1  first sample of a frame (qualified by valid).
- eop  out  1  last sample of a frame (qualified by valid).
- busy  out  1  high from start acceptance until the last valid sample.
- done  out  1  one-cycle pulse in the cycle after the last valid sample.

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, accumulator 0, counters 0, LFSRs to seed.
- States and transitions:
  - IDLE: on start, latch freq_word, phi2, phi3 and amp_shift; clear accumulator; go to RUN; busy=1. Later changes to these inputs are ignored until the next start.
  - RUN: issue one sample per cycle.
    - Sample n uses phase acc_n = n*freq_word mod 2^PHASE_W. Antenna k phase = acc_n + phi_k mod 2^PHASE_W, with phi_1 = 0.
    - Sample counter is FFT bits; frame counter counts to RUNS.
    - Accumulator runs continuously across frames (no reset between frames).
    - After the final eop sample of run RUNS, or the first eop at or after stop was seen (sticky stop), go to DRAIN.
    - stop and eop in the same cycle: that eop is the last sample.
  - DRAIN: wait for the pipeline to empty. When the last valid leaves: busy=0, done=1 for one cycle, return to IDLE.
- start in RUN or DRAIN is ignored. stop in IDLE is ignored and is not sticky.
- Latency: 3-stage pipeline (accumulator, LUT read, sign/shift/output register). valid first asserts on the 3rd rising edge after the edge that samples start. sop/eop travel with their sample.
- LUT: entry i = round((2^(WIDTH-1)-1) * sin(2π(i+0.5)/2^(LUT_AW+2))), i in 0..2^LUT_AW-1.
- Address = phase[PHASE_W-1 -: LUT_AW+2]; the top 2 bits select the quadrant.
  - Q1: index i, positive.
  - Q2: mirrored index, positive.
  - Q3: index i, negative.
  - Q4: mirrored index, negative.
- Output = quadrant-signed LUT value, arithmetic-shifted right by amp_shift. Shifts of 13 or more give 0 or -1.
- freq_word=0 gives a constant output (legal).
- Outputs hold their last value when valid=0; they go to 0 only on reset.

Optional Feature:
- Macro ANT_NOISE_EN.
- Defined: each antenna has an independent 16-bit LFSR (x^16+x^14+x^13+x^11+1, distinct nonzero seeds) advancing on every issued sample. Two LFSR bits form a signed dither of -2..+1, added after the shift with saturation to Q<WIDTH>.0 limits.
- Undefined: no LFSRs; outputs are exact as in the LUT definition.

Decomposition:
- pr3_pkg holds:
  - state enum (IDLE, RUN, DRAIN);
  - pipeline depth constant TONE_LAT=3;
  - LFSR polynomial and seed constants.
- Sub-module sine_quarter_lut: registered ROM generated by a function at elaboration. antenna_tone_gen instantiates it three times (one per antenna).

Test Plan (WIDTH=14, PHASE_W=16, LUT_AW=8, FFT=4, RUNS=2, no ANT_NOISE_EN):
- Assert reset, then release -> all outputs 0, busy=0, done=0. start=0 for 10 cycles -> no valid.
- freq_word=0x4000, phi2=phi3=0, amp_shift=0, start -> valid on 3rd edge. data1 = 25, 8191, -25, -8191 repeating; data2=data3=data1.
- Same, but phi2=0x4000, phi3=0x8000 -> data2 = 8191, -25, -8191, 25; data3 = -25, -8191, 25, 8191.
- Framing -> exactly 32 valid cycles; sop at samples 0 and 16; eop at 15 and 31; done 1 cycle after sample 31; busy falls with done. start pulsed mid-run is ignored.
- stop pulsed at sample 5 -> last valid is sample 15 with eop; 16 samples total; done follows.
- amp_shift=3 -> peaks 1023 and -1024. Reset asserted at sample 7 -> outputs 0 and busy 0 immediately. A new start after release restarts from sample 0 with sop.
